// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiply/divide unit (MULTU/MULT/DIVU/DIV).
// One iteration per cycle for WIDTH cycles. Results land in HI/LO at completion.
// Build option: define MULDIV_DIV_EN to include the restoring divider. Without it,
// divide ops keep the same handshake and latency but complete with hi=lo=0, div_zero=0.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               s1_q, s1_d;      // sign of In1 (signed ops only)
   logic               s2_q, s2_d;      // sign of In2 (signed ops only)
   logic [WIDTH-1:0]   a_q, a_d;        // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] p_q, p_d;        // {partial product, multiplier} or {remainder, quotient}
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dz_q, dz_d;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod;
   logic               last;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]     div_sh;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
`endif

   // Conditional two's-complement negate; used both for taking magnitudes and sign fix-up.
   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = dz_q;

   // Next-state, handshake outputs and one datapath iteration.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      a_d     = a_q;
      p_d     = p_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      busy    = 1'b0;
      done    = 1'b0;
      prod    = '0;
      last    = (cnt_q == CW'(WIDTH-1));

      // Shift-add step: conditionally add multiplicand into upper half, shift right.
      mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : '0)};
      mul_next = {mul_sum, p_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      // Restoring step: shift next dividend bit into remainder, keep the subtraction if it fits.
      div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, a_q};
      div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
               op_d    = op;
               s1_d    = op[0] & In1[WIDTH-1];
               s2_d    = op[0] & In2[WIDTH-1];
               if (op[1]) begin
                  a_d = cneg(In2, op[0] & In2[WIDTH-1]);
                  p_d = {{WIDTH{1'b0}}, cneg(In1, op[0] & In1[WIDTH-1])};
               end else begin
                  a_d = cneg(In1, op[0] & In1[WIDTH-1]);
                  p_d = {{WIDTH{1'b0}}, cneg(In2, op[0] & In2[WIDTH-1])};
               end
            end
         end
         RUN: begin
            busy  = 1'b1;
            cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
            p_d   = op_q[1] ? div_next : mul_next;
`else
            p_d   = mul_next;
`endif
            if (last) begin
               state_d = DONE;
               if (!op_q[1]) begin
                  prod = cneg2(p_d, s1_q ^ s2_q);
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
                  dz_d = 1'b0;
               end else begin
`ifdef MULDIV_DIV_EN
                  // With a zero divisor the remainder path returns the dividend unchanged.
                  hi_d = cneg(p_d[2*WIDTH-1:WIDTH], s1_q);
                  lo_d = (a_q == '0) ? '1 : cneg(p_d[WIDTH-1:0], s1_q ^ s2_q);
                  dz_d = (a_q == '0);
`else
                  hi_d = '0;
                  lo_d = '0;
                  dz_d = 1'b0;
`endif
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, control and datapath registers; synchronous active-low reset clears all.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         a_q     <= '0;
         p_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         a_q     <= a_d;
         p_q     <= p_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed expectations.
// Divide expectations follow MULDIV_DIV_EN (zeros when the divider is not built).
`timescale 1ns/1ps
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] In1 = '0;
   logic [31:0] In2 = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_pass = 0;

   // Results captured by do_op
   int          busy_n, done_n, done_at, hold_err;
   logic [31:0] r_hi, r_lo;
   logic        r_dz;
   logic        rb_busy;
   logic [31:0] rb_hi, rb_lo;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .In1(In1), .In2(In2), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Issue one op and watch 40 cycles. inj_k: cycle to pulse a rogue start; rst_k: cycle to assert reset.
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_k, input int rst_k);
      logic [31:0] hi0, lo0;
      @(negedge clk);
      start = 1'b1; op = o; In1 = a; In2 = b;
      @(negedge clk);
      start = 1'b0;
      busy_n = 0; done_n = 0; done_at = 0; hold_err = 0;
      r_hi = '0; r_lo = '0; r_dz = 1'b0;
      hi0 = hi; lo0 = lo;
      for (int k = 1; k <= 40; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at == 0) done_at = k;
            r_hi = hi; r_lo = lo; r_dz = div_zero;
         end else if (k <= 32 && rst_k == 0 && (hi !== hi0 || lo !== lo0)) begin
            hold_err++;
         end
         if (rst_k > 0 && k == rst_k + 1) begin
            rb_busy = busy; rb_hi = hi; rb_lo = lo;
            rst_n = 1'b1;
         end
         if (inj_k > 0 && k == inj_k) begin
            start = 1'b1; op = 2'b00; In1 = 32'd9; In2 = 32'd9;
         end
         if (inj_k > 0 && k == inj_k + 1) start = 1'b0;
         if (rst_k > 0 && k == rst_k) rst_n = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_hi",   64'(hi),   64'(0));
      chk("rst_lo",   64'(lo),   64'(0));
      chk("rst_dz",   64'(div_zero), 64'(0));
      rst_n = 1'b1;

      // MULTU max * max, with latency and hold checks
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("multu_hi",   64'(r_hi), 64'(32'hFFFF_FFFE));
      chk("multu_lo",   64'(r_lo), 64'(32'h0000_0001));
      chk("multu_busy", 64'(busy_n), 64'(32));
      chk("multu_done_at", 64'(done_at), 64'(33));
      chk("multu_done_n",  64'(done_n), 64'(1));
      chk("multu_hold", 64'(hold_err), 64'(0));

      // MULT -3 * 7
      do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0);
      chk("mult_hi", 64'(r_hi), 64'(32'hFFFF_FFFF));
      chk("mult_lo", 64'(r_lo), 64'(32'hFFFF_FFEB));
      chk("mult_dz", 64'(r_dz), 64'(0));
      chk("mult_hold", 64'(hold_err), 64'(0));

      // DIVU 100 / 7
      do_op(2'b10, 32'd100, 32'd7, 0, 0);
      chk("divu_lo", 64'(r_lo), DIV_EN ? 64'(14) : 64'(0));
      chk("divu_hi", 64'(r_hi), DIV_EN ? 64'(2)  : 64'(0));
      chk("divu_dz", 64'(r_dz), 64'(0));
      chk("divu_done_at", 64'(done_at), 64'(33));

      // DIV -7 / 2
      do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
      chk("div_neg_lo", 64'(r_lo), DIV_EN ? 64'(32'hFFFF_FFFD) : 64'(0));
      chk("div_neg_hi", 64'(r_hi), DIV_EN ? 64'(32'hFFFF_FFFF) : 64'(0));
      chk("div_neg_dz", 64'(r_dz), 64'(0));

      // DIV 7 / -2
      do_op(2'b11, 32'd7, 32'hFFFF_FFFE, 0, 0);
      chk("div_nd_lo", 64'(r_lo), DIV_EN ? 64'(32'hFFFF_FFFD) : 64'(0));
      chk("div_nd_hi", 64'(r_hi), DIV_EN ? 64'(32'h0000_0001) : 64'(0));

      // DIV most-negative / -1 wraps
      do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      chk("div_ovf_lo", 64'(r_lo), DIV_EN ? 64'(32'h8000_0000) : 64'(0));
      chk("div_ovf_hi", 64'(r_hi), 64'(0));
      chk("div_ovf_dz", 64'(r_dz), 64'(0));

      // DIVU by zero
      do_op(2'b10, 32'd5, 32'd0, 0, 0);
      chk("dz_lo", 64'(r_lo), DIV_EN ? 64'(32'hFFFF_FFFF) : 64'(0));
      chk("dz_hi", 64'(r_hi), DIV_EN ? 64'(5) : 64'(0));
      chk("dz_flag", 64'(r_dz), DIV_EN ? 64'(1) : 64'(0));
      chk("dz_busy", 64'(busy_n), 64'(32));
      chk("dz_done_at", 64'(done_at), 64'(33));

      // MULTU 2*3 clears div_zero
      do_op(2'b00, 32'd2, 32'd3, 0, 0);
      chk("mul23_hi", 64'(r_hi), 64'(0));
      chk("mul23_lo", 64'(r_lo), 64'(6));
      chk("mul23_dz", 64'(r_dz), 64'(0));

      // Start pulsed in RUN cycle 5 with new operands is ignored
      do_op(2'b00, 32'h1234_5678, 32'h0000_0010, 5, 0);
      chk("inj_hi", 64'(r_hi), 64'(32'h0000_0001));
      chk("inj_lo", 64'(r_lo), 64'(32'h2345_6780));
      chk("inj_done_n", 64'(done_n), 64'(1));
      chk("inj_busy", 64'(busy_n), 64'(32));

      // Reset asserted in RUN cycle 10 aborts the op
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10);
      chk("abort_busy", 64'(rb_busy), 64'(0));
      chk("abort_hi",   64'(rb_hi),   64'(0));
      chk("abort_lo",   64'(rb_lo),   64'(0));
      chk("abort_done_n", 64'(done_n), 64'(0));

      // Fresh MULTU after reset
      do_op(2'b00, 32'd4, 32'd5, 0, 0);
      chk("post_rst_lo", 64'(r_lo), 64'(20));
      chk("post_rst_hi", 64'(r_hi), 64'(0));
      chk("post_rst_done_at", 64'(done_at), 64'(33));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
